// File: rtl/usb_in_packetizer.sv
// usb_in_packetizer: reader-side engine for a USB device IN endpoint.
// It drains the endpoint byte queue into a local packet buffer. On an IN token
// it emits DATAx PID + payload + CRC16, or a NAK, to the serializer.
// A sent packet stays frozen until the host ACKs it, so retries resend identical data.
// Optional feature macro: USB_IN_ZLP_EN. When defined, a token that finds an
// empty, non-pending buffer sends a zero-length data packet instead of a NAK.
module usb_in_packetizer #(
    parameter int MAX_PKT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fifo_data,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    input  logic       in_token,
    input  logic       host_ack,
    input  logic       toggle_clr,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       tx_last,
    output logic       pending,
    output logic       toggle
);
    localparam int CNT_W = $clog2(MAX_PKT + 1);
    localparam int ADR_W = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT);
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_NAK   = 8'h5A;

    typedef enum logic [2:0] {
        IDLE, SEND_PID, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI, SEND_NAK
    } state_t;

    state_t           state, state_n;
    logic [7:0]       pkt_mem [0:MAX_PKT-1];
    logic [CNT_W-1:0] issued, issued_n, len, len_n, idx, idx_n, idx_inc;
    logic [15:0]      crc, crc_n;
    logic             pending_n, toggle_n;
    logic [7:0]       tx_data_n;
    logic             tx_valid_n, tx_last_n;
    logic             rd_p1;
    logic [ADR_W-1:0] wr_addr_p1, rd_addr;
    logic [7:0]       rd_byte;
    logic             accept, ack_ok;

    // One byte of the USB CRC16 in reflected form (0x8005 reversed is 0xA001).
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    // Fill only while idle and unfrozen; a sampled token stops the pop in that same cycle.
    assign fifo_rd  = (state == IDLE) && !pending && !fifo_empty && (issued < MAX_CNT) && !in_token;
    assign accept   = tx_valid && tx_ready;
    assign ack_ok   = (state == IDLE) && pending && host_ack;
    assign idx_inc  = idx + 1'b1;
    assign rd_addr  = (state == SEND_PID) ? '0 : idx_inc[ADR_W-1:0];
    assign rd_byte  = pkt_mem[rd_addr];

    // Remember each pop so the returned byte lands in the slot reserved for it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_p1      <= 1'b0;
            wr_addr_p1 <= '0;
        end else begin
            rd_p1      <= fifo_rd;
            wr_addr_p1 <= issued[ADR_W-1:0];
        end
    end

    // Packet buffer write, one cycle after the pop, regardless of the FSM state.
    always_ff @(posedge clk) begin
        if (rd_p1)
            pkt_mem[wr_addr_p1] <= fifo_data;
    end

    // Next-state and next-output logic; the ACK is applied before the token is evaluated.
    always_comb begin
        state_n    = state;
        tx_data_n  = tx_data;
        tx_valid_n = tx_valid;
        tx_last_n  = tx_last;
        issued_n   = issued;
        len_n      = len;
        idx_n      = idx;
        crc_n      = crc;
        pending_n  = pending;
        toggle_n   = toggle;

        if (fifo_rd)
            issued_n = issued + 1'b1;
        if (ack_ok) begin
            pending_n = 1'b0;
            issued_n  = '0;
            toggle_n  = ~toggle;
        end
        if (toggle_clr)
            toggle_n = 1'b0;

        case (state)
            IDLE: begin
                if (in_token) begin
                    if ((issued_n != '0) || pending_n) begin
                        state_n    = SEND_PID;
                        len_n      = issued_n;
                        tx_data_n  = toggle_n ? PID_DATA1 : PID_DATA0;
                        tx_valid_n = 1'b1;
                        tx_last_n  = 1'b0;
                    end else begin
`ifdef USB_IN_ZLP_EN
                        state_n    = SEND_PID;
                        len_n      = '0;
                        tx_data_n  = toggle_n ? PID_DATA1 : PID_DATA0;
                        tx_valid_n = 1'b1;
                        tx_last_n  = 1'b0;
`else
                        state_n    = SEND_NAK;
                        tx_data_n  = PID_NAK;
                        tx_valid_n = 1'b1;
                        tx_last_n  = 1'b1;
`endif
                    end
                end
            end
            SEND_PID: begin
                if (accept) begin
                    crc_n = 16'hFFFF;
                    idx_n = '0;
                    if (len != '0) begin
                        state_n   = SEND_DATA;
                        tx_data_n = rd_byte;
                    end else begin
                        state_n   = SEND_CRC_LO;
                        tx_data_n = 8'h00;
                    end
                end
            end
            SEND_DATA: begin
                if (accept) begin
                    crc_n = crc16_byte(crc, tx_data);
                    idx_n = idx_inc;
                    if (idx_inc < len) begin
                        tx_data_n = rd_byte;
                    end else begin
                        state_n   = SEND_CRC_LO;
                        tx_data_n = ~crc_n[7:0];
                    end
                end
            end
            SEND_CRC_LO: begin
                if (accept) begin
                    state_n   = SEND_CRC_HI;
                    tx_data_n = ~crc[15:8];
                    tx_last_n = 1'b1;
                end
            end
            SEND_CRC_HI: begin
                if (accept) begin
                    state_n    = IDLE;
                    tx_data_n  = 8'h00;
                    tx_valid_n = 1'b0;
                    tx_last_n  = 1'b0;
                    pending_n  = 1'b1;
                end
            end
            SEND_NAK: begin
                if (accept) begin
                    state_n    = IDLE;
                    tx_data_n  = 8'h00;
                    tx_valid_n = 1'b0;
                    tx_last_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            issued   <= '0;
            len      <= '0;
            idx      <= '0;
            crc      <= 16'hFFFF;
            pending  <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            state    <= state_n;
            tx_data  <= tx_data_n;
            tx_valid <= tx_valid_n;
            tx_last  <= tx_last_n;
            issued   <= issued_n;
            len      <= len_n;
            idx      <= idx_n;
            crc      <= crc_n;
            pending  <= pending_n;
            toggle   <= toggle_n;
        end
    end
endmodule

// File: tb/tb_usb_in_packetizer.sv
// Self-checking bench for usb_in_packetizer: table-driven protocol steps,
// hand-written corner sequences, and randomized packets against a queue-based model.
module tb_usb_in_packetizer;
    localparam int MAXP = 64;
`ifdef USB_IN_ZLP_EN
    localparam bit ZLP = 1'b1;
`else
    localparam bit ZLP = 1'b0;
`endif
    localparam int A_PUSH = 0, A_TOKEN = 1, A_ACK = 2, A_CLR = 3;

    typedef struct {
        int         act;
        logic [7:0] exp_first;
        int         exp_len;
        int         exp_pops;
        logic       exp_pending;
        logic       exp_toggle;
    } step_t;

    logic clk, rst;
    logic [7:0] fifo_data, tx_data;
    logic fifo_empty, fifo_rd, in_token, host_ack, toggle_clr;
    logic tx_valid, tx_ready, tx_last, pending, toggle;
    logic [7:0] fifo_data8, tx_data8;
    logic fifo_empty8, fifo_rd8, in_token8, host_ack8, toggle_clr8;
    logic tx_valid8, tx_ready8, tx_last8, pending8, toggle8;

    int tests = 0, fails = 0;
    int pops = 0, fcnt = 0, pops8 = 0, fcnt8 = 0;
    int rdy_mode = 0;
    logic [7:0] fq[$], fq8[$];
    logic [7:0] cap_q[$], cap8[$];
    logic       cap_last[$], last8[$];
    logic [7:0] m_q[$], m_pl[$];
    bit m_pending = 0, m_toggle = 0;
    logic hold_v = 0, hold_l = 0;
    logic [7:0] hold_d = 0;

    usb_in_packetizer #(.MAX_PKT(MAXP)) dut (
        .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .in_token(in_token), .host_ack(host_ack), .toggle_clr(toggle_clr), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last), .pending(pending), .toggle(toggle)
    );
    usb_in_packetizer #(.MAX_PKT(8)) dut8 (
        .clk(clk), .rst(rst), .fifo_data(fifo_data8), .fifo_empty(fifo_empty8), .fifo_rd(fifo_rd8),
        .in_token(in_token8), .host_ack(host_ack8), .toggle_clr(toggle_clr8), .tx_data(tx_data8),
        .tx_valid(tx_valid8), .tx_ready(tx_ready8), .tx_last(tx_last8), .pending(pending8), .toggle(toggle8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // External byte queues: data appears the cycle after a pop.
    assign fifo_empty  = (fcnt == 0);
    assign fifo_empty8 = (fcnt8 == 0);
    always @(posedge clk) begin
        if (fifo_rd) begin
            if (fq.size() > 0) fifo_data <= fq.pop_front();
            fcnt <= fcnt - 1;
            pops++;
        end
        if (fifo_rd8) begin
            if (fq8.size() > 0) fifo_data8 <= fq8.pop_front();
            fcnt8 <= fcnt8 - 1;
            pops8++;
        end
    end

    // Serializer ready pattern: always ready, alternating, or random.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      tx_ready = 1'b1;
        else if (rdy_mode == 1) tx_ready = ~tx_ready;
        else                    tx_ready = 1'($urandom_range(0, 1));
    end

    // Capture accepted bytes and check that stalled outputs hold steady.
    always @(negedge clk) begin
        if (!rst) hold_v = 1'b0;
        else begin
            if (hold_v) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, hold_d);
                check("hold_last", tx_last, hold_l);
            end
            hold_v = tx_valid && !tx_ready;
            hold_d = tx_data;
            hold_l = tx_last;
            if (tx_valid && tx_ready) begin
                cap_q.push_back(tx_data);
                cap_last.push_back(tx_last);
            end
        end
        if (rst && tx_valid8) begin
            cap8.push_back(tx_data8);
            last8.push_back(tx_last8);
        end
    end

    // Bit-serial CRC16 on polynomial 0x8005, bits fed LSB first, result reflected and inverted.
    function automatic logic [15:0] ref_crc(input logic [7:0] d[$]);
        logic [15:0] c, r;
        logic fb;
        c = 16'hFFFF;
        foreach (d[i])
            for (int b = 0; b < 8; b++) begin
                fb = d[i][b] ^ c[15];
                c = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        for (int i = 0; i < 16; i++) r[i] = c[15-i];
        return ~r;
    endfunction

    task automatic model_token(output logic [7:0] exp[$]);
        logic [7:0] pl[$];
        logic [15:0] c;
        exp = {};
        if (m_pending) pl = m_pl;
        else for (int i = 0; i < m_q.size() && i < MAXP; i++) pl.push_back(m_q[i]);
        if (!m_pending && pl.size() == 0 && !ZLP) begin
            exp.push_back(8'h5A);
            return;
        end
        exp.push_back(m_toggle ? 8'h4B : 8'hC3);
        foreach (pl[i]) exp.push_back(pl[i]);
        c = ref_crc(pl);
        exp.push_back(c[7:0]);
        exp.push_back(c[15:8]);
        m_pl = pl;
        m_pending = 1;
    endtask

    task automatic model_ack();
        if (m_pending) begin
            repeat (m_pl.size()) void'(m_q.pop_front());
            m_pending = 0;
            m_toggle = ~m_toggle;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n, input bit rnd);
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            v = rnd ? 8'($urandom_range(0, 255)) : first + 8'(i);
            fq.push_back(v);
            m_q.push_back(v);
        end
        fcnt = fcnt + n;
    endtask

    task automatic pulse(input bit tok, input bit ack, input bit clr);
        @(posedge clk); #1;
        in_token = tok; host_ack = ack; toggle_clr = clr;
        @(posedge clk); #1;
        in_token = 0; host_ack = 0; toggle_clr = 0;
    endtask

    task automatic token_collect(input bit with_ack);
        bit done;
        cap_q.delete(); cap_last.delete();
        pulse(1'b1, with_ack, 1'b0);
        done = 0;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (cap_last.size() > 0 && cap_last[$]) done = 1;
            else cycles(1);
        end
        if (!done) check("packet_timeout", 0, 1);
        cycles(1);
    endtask

    task automatic compare_pkt(input string tag, input logic [7:0] exp[$]);
        int nl = 0;
        check({tag, "_len"}, cap_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), cap_q[i], exp[i]);
        foreach (cap_last[i]) if (cap_last[i]) nl++;
        check({tag, "_last_count"}, nl, 1);
        if (cap_last.size() > 0) check({tag, "_last_pos"}, cap_last[$], 1);
    endtask

    task automatic do_reset();
        rst = 0; in_token = 0; host_ack = 0; toggle_clr = 0;
        cycles(3);
        rst = 1;
        m_pending = 0; m_toggle = 0; m_q = fq;
        cycles(1);
    endtask

    step_t steps[16];
    logic [7:0] exp[$], golden[$];
    int p0;
    bit aborted;

    initial begin
        golden = '{8'hC3, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
        steps[0]  = '{A_PUSH,  8'h00, 0,  9, 1'b0, 1'b0};
        steps[1]  = '{A_TOKEN, 8'hC3, 12, 0, 1'b1, 1'b0};
        steps[2]  = '{A_TOKEN, 8'hC3, 12, 0, 1'b1, 1'b0};
        steps[3]  = '{A_ACK,   8'h00, 0,  0, 1'b0, 1'b1};
`ifdef USB_IN_ZLP_EN
        steps[4]  = '{A_TOKEN, 8'h4B, 3,  0, 1'b1, 1'b1};
        steps[5]  = '{A_ACK,   8'h00, 0,  0, 1'b0, 1'b0};
        steps[6]  = '{A_PUSH,  8'h00, 0,  9, 1'b0, 1'b0};
        steps[7]  = '{A_TOKEN, 8'hC3, 12, 0, 1'b1, 1'b0};
        steps[8]  = '{A_ACK,   8'h00, 0,  0, 1'b0, 1'b1};
`else
        steps[4]  = '{A_TOKEN, 8'h5A, 1,  0, 1'b0, 1'b1};
        steps[5]  = '{A_ACK,   8'h00, 0,  0, 1'b0, 1'b1};
        steps[6]  = '{A_PUSH,  8'h00, 0,  9, 1'b0, 1'b1};
        steps[7]  = '{A_TOKEN, 8'h4B, 12, 0, 1'b1, 1'b1};
        steps[8]  = '{A_ACK,   8'h00, 0,  0, 1'b0, 1'b0};
`endif
        steps[9]  = '{A_PUSH,  8'h00, 0,  9, 1'b0, steps[8].exp_toggle};
        steps[10] = '{A_TOKEN, steps[8].exp_toggle ? 8'h4B : 8'hC3, 12, 0, 1'b1, steps[8].exp_toggle};
        steps[11] = '{A_ACK,   8'h00, 0,  0, 1'b0, ~steps[8].exp_toggle};
        steps[12] = '{A_CLR,   8'h00, 0,  0, 1'b0, 1'b0};
        steps[13] = '{A_PUSH,  8'h00, 0,  9, 1'b0, 1'b0};
        steps[14] = '{A_TOKEN, 8'hC3, 12, 0, 1'b1, 1'b0};
        steps[15] = '{A_ACK,   8'h00, 0,  0, 1'b0, 1'b1};

        rst = 0; in_token = 0; host_ack = 0; toggle_clr = 0; tx_ready = 1;
        in_token8 = 0; host_ack8 = 0; toggle_clr8 = 0; tx_ready8 = 1;
        cycles(2);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_last", tx_last, 0);
        check("rst_pending", pending, 0);
        check("rst_toggle", toggle, 0);
        do_reset();

        for (int i = 0; i < 16; i++) begin
            p0 = pops;
            case (steps[i].act)
                A_PUSH: begin push_bytes(8'h31, 9, 0); cycles(30); end
                A_TOKEN: begin
                    model_token(exp);
                    token_collect(0);
                    compare_pkt($sformatf("step%0d", i), exp);
                    check($sformatf("step%0d_first", i), (cap_q.size() > 0) ? cap_q[0] : 8'h00, steps[i].exp_first);
                    check($sformatf("step%0d_count", i), cap_q.size(), steps[i].exp_len);
                end
                A_ACK: begin pulse(0, 1, 0); model_ack(); cycles(2); end
                default: begin pulse(0, 0, 1); m_toggle = 0; cycles(2); end
            endcase
            check($sformatf("step%0d_pops", i), pops - p0, steps[i].exp_pops);
            check($sformatf("step%0d_pending", i), pending, steps[i].exp_pending);
            check($sformatf("step%0d_toggle", i), toggle, steps[i].exp_toggle);
        end

        // Golden packet with the serializer stalling every other cycle.
        do_reset();
        push_bytes(8'h31, 9, 0);
        cycles(30);
        rdy_mode = 1;
        void'(model_token_wrap());
        token_collect(0);
        rdy_mode = 0;
        compare_pkt("golden", golden);
        check("golden_pending", pending, 1);

        // Token and ACK in the same idle cycle: ACK first, then the token sees an empty buffer.
        model_ack();
        model_token(exp);
        token_collect(1);
        compare_pkt("tok_ack", exp);
        check("tok_ack_toggle", toggle, 1);
        check("tok_ack_pending", pending, ZLP);
        if (ZLP) begin pulse(0, 1, 0); model_ack(); cycles(2); end

        // Reset in the middle of a payload.
        do_reset();
        push_bytes(8'h31, 9, 0);
        cycles(30);
        model_token(exp);
        token_collect(0);
        pulse(0, 1, 0); model_ack();
        check("pre_rst_toggle", toggle, 1);
        push_bytes(8'h61, 9, 0);
        cycles(30);
        cap_q.delete(); cap_last.delete();
        pulse(1, 0, 0);
        aborted = 0;
        for (int i = 0; i < 100 && !aborted; i++) begin
            if (cap_q.size() >= 4) aborted = 1;
            else cycles(1);
        end
        check("mid_reached", aborted, 1);
        rst = 0;
        #1;
        check("async_tx_valid", tx_valid, 0);
        cycles(2);
        rst = 1;
        m_pending = 0; m_toggle = 0; m_q = fq;
        cycles(1);
        check("post_rst_toggle", toggle, 0);
        check("post_rst_pending", pending, 0);
        p0 = pops;
        push_bytes(8'h71, 9, 0);
        cycles(30);
        check("post_rst_pops", pops - p0, 9);
        model_token(exp);
        token_collect(0);
        compare_pkt("post_rst", exp);
        check("post_rst_pid", (cap_q.size() > 0) ? cap_q[0] : 8'h00, 8'hC3);

        // Randomized traffic against the model.
        for (int it = 0; it < 25; it++) begin
            push_bytes(8'h00, $urandom_range(0, 40), 1);
            cycles(80);
            rdy_mode = $urandom_range(0, 2);
            model_token(exp);
            token_collect(0);
            rdy_mode = 0;
            compare_pkt($sformatf("rnd%0d", it), exp);
            check($sformatf("rnd%0d_pending", it), pending, m_pending);
            if ($urandom_range(0, 3) != 0) begin pulse(0, 1, 0); model_ack(); end
            if (!m_pending && $urandom_range(0, 4) == 0) begin pulse(0, 0, 1); m_toggle = 0; end
            cycles(2);
            check($sformatf("rnd%0d_toggle", it), toggle, m_toggle);
        end

        // Small buffer: fill stops at 8, leftovers wait for the ACK.
        for (int i = 0; i < 20; i++) fq8.push_back(8'h40 + 8'(i));
        fcnt8 = 20;
        cycles(40);
        check("mp8_pops", pops8, 8);
        check("mp8_left", fcnt8, 12);
        cap8.delete(); last8.delete();
        @(posedge clk); #1 in_token8 = 1;
        @(posedge clk); #1 in_token8 = 0;
        cycles(20);
        exp = {};
        for (int i = 0; i < 8; i++) exp.push_back(8'h40 + 8'(i));
        check("mp8_len", cap8.size(), 11);
        check("mp8_pid", (cap8.size() > 0) ? cap8[0] : 8'h00, 8'hC3);
        for (int i = 0; i < 8 && i + 1 < cap8.size(); i++)
            check($sformatf("mp8_byte%0d", i), cap8[i+1], exp[i]);
        if (cap8.size() == 11) begin
            check("mp8_crc_lo", cap8[9], ref_crc(exp) & 16'h00FF);
            check("mp8_crc_hi", cap8[10], ref_crc(exp) >> 8);
            check("mp8_last", last8[10], 1);
        end
        check("mp8_pops_after_tok", pops8, 8);
        @(posedge clk); #1 host_ack8 = 1;
        @(posedge clk); #1 host_ack8 = 0;
        cycles(40);
        check("mp8_pops_after_ack", pops8, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic bit model_token_wrap();
        m_pending = 1;
        m_pl = {};
        for (int i = 0; i < 9; i++) m_pl.push_back(m_q[i]);
        return 1'b1;
    endfunction
endmodule

// File: doc/usb_in_packetizer.md
# usb_in_packetizer

Reader-side endpoint engine for the USB device IN path. Drains bytes from the endpoint's byte queue into a local packet buffer. On an IN token it emits one USB data packet (DATAx PID, payload, CRC16) or a NAK as a byte stream to the downstream bit-level serializer. Packets are retained until ACKed so a retry resends identical data, and the data-toggle PID is tracked.

## Interface
- MAX_PKT, 64: max payload bytes per packet (8..1023); also the local buffer depth.
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- fifo_data  in  8  queue read data; valid the cycle after fifo_rd.
- fifo_empty  in  1  queue empty flag.
- fifo_rd  out  1  queue pop request; one byte per asserted cycle.
- in_token  in  1  one-cycle pulse: host IN token addressed to this endpoint.
- host_ack  in  1  one-cycle pulse: host ACK received for the last data packet.
- toggle_clr  in  1  one-cycle pulse: force next data PID to DATA0 (SetConfiguration/ClearFeature).
- tx_data  out  8  byte to serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts byte when tx_valid & tx_ready.
- tx_last  out  1  marks the final byte of the packet.
- pending  out  1  a sent packet awaits ACK; buffer is frozen.
- toggle  out  1  PID for the next/current data packet: 0 = DATA0, 1 = DATA1.

## Operation
- States: IDLE, SEND_PID, SEND_DATA, SEND_CRC_LO, SEND_CRC_HI, SEND_NAK.
- Fill: fifo_rd = IDLE & !pending & !fifo_empty & issued < MAX_PKT. The issued count increments per pop. The byte returned next cycle is written to buf[issued-1], even if the state has already left IDLE.
- IDLE + in_token:
  - issued > 0 or pending: freeze len = issued and go to SEND_PID.
  - otherwise go to SEND_NAK.
- in_token outside IDLE is ignored.
- PID bytes: DATA0 = 8'hC3, DATA1 = 8'h4B, NAK = 8'h5A.
- Byte order: PID, buf[0..len-1], ~crc[7:0], ~crc[15:8]. tx_last is asserted with the CRC high byte, or with the NAK byte. Afterwards the engine returns to IDLE; a data packet sets pending.
- CRC16: polynomial 0x8005, init 16'hFFFF, data processed LSB-first, output inverted. It is reset when the PID is accepted and updated on each accepted payload byte.
- Retry: in_token while pending resends the same len, bytes and PID. No queue pops occur.
- host_ack in IDLE while pending: clear pending, issued = 0, toggle ^= 1, and resume fill. host_ack in any other condition is ignored.
- toggle_clr: toggle = 0 at any time. It takes precedence over a same-cycle ACK flip.

## Timing
- Reset values: fifo_rd 0, tx_valid 0, tx_data 8'h00, tx_last 0, pending 0, toggle 0, state IDLE, issued 0.
- Reset mid-packet aborts immediately, with tx_valid low asynchronously. Buffered bytes are discarded and not re-popped.
- The first tx_valid appears the cycle after in_token is sampled.
- Outputs are registered. tx_data, tx_valid and tx_last hold stable while tx_valid & !tx_ready.
- Fill throughput: one byte per cycle. fifo_rd deasserts in the cycle in_token is sampled.
- issued is $clog2(MAX_PKT+1) bits wide and saturates at MAX_PKT (no wrap). Buffer indices are zero-based, with no wrap-around.
- Simultaneous in_token and host_ack in IDLE: the ACK is applied first, then the token is evaluated against the now-cleared buffer (typically NAK).

## Configuration
- USB_IN_ZLP_EN defined: a token with an empty, non-pending buffer sends a zero-length data packet (PID, 8'h00, 8'h00) and sets pending; its ACK toggles the PID.
- USB_IN_ZLP_EN undefined: that case sends NAK, and pending stays 0.

## Test plan
- Reset, queue holds 31..39 (ASCII "123456789"), token -> C3 31 32 33 34 35 36 37 38 39 C8 B4, tx_last on B4, pending=1.
- Same packet, no ACK, second token -> identical byte sequence, zero fifo_rd pulses; then host_ack -> pending=0, toggle=1, and the next packet starts with 4B.
- Empty queue, token, macro undefined -> single byte 5A with tx_last; with USB_IN_ZLP_EN -> C3 00 00.
- MAX_PKT=8, 20 bytes queued -> exactly 8 pops, then token -> 8-byte payload; remaining 12 stay in the queue until ACK.
- tx_ready toggling 1/0 every cycle during send -> the byte sequence is unchanged and held bytes are stable.
- Assert rst mid-payload, then token after release -> toggle=0, pending=0, new fill from the queue, and the packet starts with C3.
